// File: rtl/tts_pkg.sv
// Shared constants and state encoding for the truth-table sequencer.
// Imported by the interface, the settle timer's parent, and the controller.
package tts_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned NUM_VEC = 1 << VEC_W;
  localparam logic [15:0] GOLDEN_DEFAULT = 16'hFFE8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control, stimulus and result bundle between a tester and the sequencer.
// The master drives start/abort and the block-under-test response y_in.
interface truth_table_sequencer_if;
  import tts_pkg::*;

  logic             start;
  logic             abort;
  logic             y_in;
  logic [VEC_W-1:0] abcd;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [15:0]      tt_word;
  logic             pass;
  logic [4:0]       mismatch_cnt;
  logic [VEC_W-1:0] first_fail_idx;

  modport master (
    output start, abort, y_in,
    input  abcd, busy, done, result_valid, tt_word, pass, mismatch_cnt, first_fail_idx
  );

  modport slave (
    input  start, abort, y_in,
    output abcd, busy, done, result_valid, tt_word, pass, mismatch_cnt, first_fail_idx
  );

endinterface

// File: rtl/settle_timer.sv
// Counts cycles while enabled and flags the last settle cycle (count == SETTLE-1).
// Held at zero whenever clear is asserted, so each vector starts from a fresh count.
module settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(SETTLE - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 {A,B,C,D} vectors through an external decision block, captures
// its Y per vector into a truth-table word and scores it against GOLDEN.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] GOLDEN = GOLDEN_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  truth_table_sequencer_if.slave  busIf
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

  state_t           state_q;
  logic [VEC_W-1:0] idx_q;
  logic [VEC_W-1:0] abcd_q;
  logic             busy_q;
  logic             done_q;
  logic             resultValid_q;
  logic [15:0]      ttWord_q;
  logic             pass_q;
  logic [4:0]       mismatchCnt_q;
  logic [VEC_W-1:0] firstFailIdx_q;

  logic             timerExpired;
  logic             sampleMiss_d;
  logic [4:0]       mismatchCnt_d;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != ST_APPLY),
    .en_i      (state_q == ST_APPLY),
    .expired_o (timerExpired)
  );

  // Gated by state so an unknown y_in outside SAMPLE never reaches the counters.
  assign sampleMiss_d  = (state_q == ST_SAMPLE) & (busIf.y_in ^ GOLDEN[idx_q]);
  assign mismatchCnt_d = mismatchCnt_q + {4'd0, sampleMiss_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      abcd_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      resultValid_q  <= 1'b0;
      ttWord_q       <= '0;
      pass_q         <= 1'b0;
      mismatchCnt_q  <= '0;
      firstFailIdx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (busIf.start) begin
            state_q        <= ST_APPLY;
            idx_q          <= '0;
            abcd_q         <= '0;
            busy_q         <= 1'b1;
            ttWord_q       <= '0;
            mismatchCnt_q  <= '0;
            firstFailIdx_q <= '0;
            resultValid_q  <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (busIf.abort) begin
            state_q <= ST_IDLE;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
          end else if (timerExpired) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // An abort on the sampling edge drops this vector's result entirely.
          if (busIf.abort) begin
            state_q <= ST_IDLE;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
          end else begin
            ttWord_q[idx_q] <= busIf.y_in;
            mismatchCnt_q   <= mismatchCnt_d;
            if (sampleMiss_d && (mismatchCnt_q == 5'd0)) begin
              firstFailIdx_q <= idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_q       <= ST_DONE;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              resultValid_q <= 1'b1;
              pass_q        <= (mismatchCnt_d == 5'd0);
            end else begin
              state_q <= ST_APPLY;
              idx_q   <= idx_q + 1'b1;
              abcd_q  <= idx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          abcd_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busIf.abcd           = abcd_q;
  assign busIf.busy           = busy_q;
  assign busIf.done           = done_q;
  assign busIf.result_valid   = resultValid_q;
  assign busIf.tt_word        = ttWord_q;
  assign busIf.pass           = pass_q;
  assign busIf.mismatch_cnt   = mismatchCnt_q;
  assign busIf.first_fail_idx = firstFailIdx_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=2 and SETTLE=1) sweep a behavioural
// decision block with injected faults; a monitor scores every done pulse.
module tb_truth_table_sequencer;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  mm;
    logic [3:0]  ffi;
    logic        pass;
    int          doneCycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cycleCount = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] respA = '0;
  logic [15:0] respB = '0;
  logic [15:0] goldenWord;
  exp_t        qA[$];
  exp_t        qB[$];
  logic        prevBusy[2];
  logic [3:0]  prevAbcd[2];
  int          runLen[2];

  truth_table_sequencer_if ifA();
  truth_table_sequencer_if ifB();

  // The block under test is a per-vector response word: the correct function or a faulty copy.
  assign ifA.y_in = respA[ifA.abcd];
  assign ifB.y_in = respB[ifB.abcd];

  truth_table_sequencer #(.SETTLE(2)) dutA (.clk(clk), .rst(rst), .busIf(ifA.slave));
  truth_table_sequencer #(.SETTLE(1)) dutB (.clk(clk), .rst(rst), .busIf(ifB.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic decide(input int v);
    int votes;
    votes = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return (v[3] == 1'b1) || (votes >= 2);
  endfunction

  function automatic int settleOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic exp_t makeExp(input logic [15:0] resp);
    exp_t e;
    logic [15:0] diff;
    diff = resp ^ goldenWord;
    e.tt = resp;
    e.mm = 5'($countones(diff));
    e.pass = (diff == 16'd0);
    e.ffi = 4'd0;
    e.doneCycle = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) e.ffi = 4'(i);
    return e;
  endfunction

  // {abcd[32:29], busy[28], done[27], valid[26], tt[25:10], pass[9], mm[8:4], ffi[3:0]}
  function automatic logic [32:0] snap(input int d);
    if (d == 0)
      return {ifA.abcd, ifA.busy, ifA.done, ifA.result_valid, ifA.tt_word,
              ifA.pass, ifA.mismatch_cnt, ifA.first_fail_idx};
    return {ifB.abcd, ifB.busy, ifB.done, ifB.result_valid, ifB.tt_word,
            ifB.pass, ifB.mismatch_cnt, ifB.first_fail_idx};
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? qA.size() : qB.size();
  endfunction

  task automatic setStart(input int d, input logic v);
    if (d == 0) ifA.start = v; else ifB.start = v;
  endtask

  task automatic setAbort(input int d, input logic v);
    if (d == 0) ifA.abort = v; else ifB.abort = v;
  endtask

  task automatic setResp(input int d, input logic [15:0] r);
    if (d == 0) respA = r; else respB = r;
  endtask

  task automatic checkDone(input int d, input logic [32:0] s);
    exp_t e;
    if (qSize(d) == 0) begin
      checkOutput($sformatf("unexpectedDone%0d", d), 32'd1, 32'd0);
      return;
    end
    e = (d == 0) ? qA.pop_front() : qB.pop_front();
    checkOutput("ttWord", 32'(s[25:10]), 32'(e.tt));
    checkOutput("mismatchCnt", 32'(s[8:4]), 32'(e.mm));
    checkOutput("firstFailIdx", 32'(s[3:0]), 32'(e.ffi));
    checkOutput("pass", 32'(s[9]), 32'(e.pass));
    checkOutput("resultValid", 32'(s[26]), 32'd1);
    checkOutput("busyAtDone", 32'(s[28]), 32'd0);
    checkOutput("doneCycle", 32'(cycleCount), 32'(e.doneCycle));
  endtask

  // Vectors must ascend by one from 0, each held for SETTLE apply cycles plus one sample cycle.
  task automatic trackVectors(input int d, input logic busy, input logic [3:0] abcd);
    if (busy && !prevBusy[d]) begin
      checkOutput("firstVector", 32'(abcd), 32'd0);
      prevAbcd[d] = abcd;
      runLen[d] = 1;
    end else if (busy) begin
      if (abcd == prevAbcd[d]) begin
        runLen[d]++;
      end else begin
        checkOutput("nextVector", 32'(abcd), 32'(4'(prevAbcd[d] + 4'd1)));
        checkOutput("holdCycles", 32'(runLen[d]), 32'(settleOf(d) + 1));
        prevAbcd[d] = abcd;
        runLen[d] = 1;
      end
    end
    prevBusy[d] = busy;
  endtask

  always @(negedge clk) begin
    logic [32:0] s;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        s = snap(d);
        if (s[27]) checkDone(d, s);
        trackVectors(d, s[28], s[32:29]);
      end
    end
  end

  task automatic waitDrained(input int d);
    int n = 0;
    while (qSize(d) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (qSize(d) != 0) begin
      checkOutput("doneTimeout", 32'(qSize(d)), 32'd0);
      if (d == 0) qA.delete(); else qB.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input int d, input logic [15:0] resp, input bit holdStart);
    exp_t e;
    setResp(d, resp);
    e = makeExp(resp);
    setStart(d, 1'b1);
    @(posedge clk);
    #1;
    e.doneCycle = cycleCount + 16 * (settleOf(d) + 1);
    if (d == 0) qA.push_back(e); else qB.push_back(e);
    if (holdStart) begin
      repeat (20) @(negedge clk);
      setStart(d, 1'b0);
      repeat (8) @(negedge clk);
      setStart(d, 1'b1);
      @(negedge clk);
      setStart(d, 1'b0);
    end else begin
      setStart(d, 1'b0);
    end
    waitDrained(d);
  endtask

  task automatic abortTest(input int d, input int v, input int offset, input logic [15:0] resp);
    logic [32:0] s;
    logic [15:0] keep;
    int n = 0;
    setResp(d, resp);
    setStart(d, 1'b1);
    @(posedge clk);
    #1;
    setStart(d, 1'b0);
    @(negedge clk);
    s = snap(d);
    while (!(s[28] && s[32:29] == 4'(v)) && n < 400) begin
      @(negedge clk);
      s = snap(d);
      n++;
    end
    if (n >= 400) begin
      checkOutput("abortVectorTimeout", 32'd1, 32'd0);
      return;
    end
    repeat (offset) @(negedge clk);
    setAbort(d, 1'b1);
    @(posedge clk);
    #1;
    setAbort(d, 1'b0);
    @(negedge clk);
    s = snap(d);
    keep = 16'((32'd1 << v) - 32'd1);
    checkOutput("abortBusy", 32'(s[28]), 32'd0);
    checkOutput("abortAbcd", 32'(s[32:29]), 32'd0);
    checkOutput("abortDone", 32'(s[27]), 32'd0);
    checkOutput("abortValid", 32'(s[26]), 32'd0);
    checkOutput("abortPartialTt", 32'(s[25:10]), 32'(resp & keep));
    repeat (60) @(negedge clk);
  endtask

  task automatic resetTest();
    setResp(0, goldenWord);
    setStart(0, 1'b1);
    @(posedge clk);
    #1;
    setStart(0, 1'b0);
    repeat ($urandom_range(5, 40)) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midResetA", 32'(snap(0)), 32'd0);
    checkOutput("midResetB", 32'(snap(1)), 32'd0);
    prevBusy[0] = 1'b0;
    prevBusy[1] = 1'b0;
  endtask

  initial begin
    ifA.start = 1'b0; ifA.abort = 1'b0;
    ifB.start = 1'b0; ifB.abort = 1'b0;
    prevBusy[0] = 1'b0; prevBusy[1] = 1'b0;
    prevAbcd[0] = 4'd0; prevAbcd[1] = 4'd0;
    runLen[0] = 0; runLen[1] = 0;
    for (int i = 0; i < 16; i++) goldenWord[i] = decide(i);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetStateA", 32'(snap(0)), 32'd0);
    checkOutput("resetStateB", 32'(snap(1)), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, goldenWord, 1'b0);
    applyStimulus(0, 16'h0000, 1'b0);
    applyStimulus(0, 16'hFFFF, 1'b0);
    applyStimulus(1, goldenWord ^ 16'h0200, 1'b0);
    applyStimulus(0, goldenWord, 1'b1);

    for (int k = 0; k < 6; k++) begin
      if (k < 3) applyStimulus(k % 2, goldenWord ^ 16'(32'd1 << $urandom_range(0, 15)), 1'b0);
      else       applyStimulus(k % 2, 16'($urandom), 1'b0);
    end

    abortTest(0, 7, 0, goldenWord);
    applyStimulus(0, goldenWord, 1'b0);
    for (int k = 0; k < 4; k++) begin
      abortTest(k % 2, int'($urandom_range(0, 15)), int'($urandom_range(0, settleOf(k % 2))), 16'($urandom));
      applyStimulus(k % 2, goldenWord, 1'b0);
    end

    resetTest();
    applyStimulus(0, goldenWord, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
